ps2_host_sequencer: RTL and testbench
=====================================

# ps2_host_sequencer

Host-side PS/2 command sequencer for the keyboard port. It brings the keyboard up after reset with a Reset command (0xFF) and checks that the keyboard reports a passing self-test. It then sends LED updates on request and handles device ACK, Resend, timeouts and bounded retries. It drives PS2_CLK/PS2_DAT open-drain beside the existing scan-code receiver and holds that receiver off while the host owns the bus.

## Interface
Parameters:
- POWERUP_CYC, 25000000, idle wait after reset before first command (500 ms)
- INHIBIT_CYC, 5000, clock-low hold before a host frame (100 µs)
- RESP_TIMEOUT_CYC, 1000000, limit for a frame transfer or ACK reply (20 ms)
- BAT_TIMEOUT_CYC, 50000000, limit for the self-test result byte after ACK of 0xFF
- MAX_RETRY, 3, resends per byte before giving up

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  synchronous, active-low
- ps2_clk_in  in  1  raw PS2_CLK pin level
- ps2_dat_in  in  1  raw PS2_DAT pin level
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- rx_byte  in  8  byte from receiver
- rx_strobe  in  1  one-cycle valid for rx_byte
- rx_inhibit  out  1  1 = receiver must discard bits
- led_state  in  3  {caps, num, scroll}
- led_req  in  1  one-cycle pulse requesting LED update
- busy  out  1  sequence in progress
- kbd_ok  out  1  last reset sequence passed
- err_cnt  out  8  failed commands, saturating at 0xFF

## Operation
- ps2_clk_in/ps2_dat_in pass through 2-FF synchronizers. Device clock fall = sync1 high and sync0 low.
- States:
  - POWERUP
  - IDLE
  - TX_INHIBIT
  - TX_START
  - TX_BITS
  - TX_ACK
  - WAIT_ACK
  - WAIT_BAT
- Transitions:
  - POWERUP waits POWERUP_CYC, loads byte 0xFF, then goes to TX_INHIBIT.
  - TX_INHIBIT: clk_oe=1 for INHIBIT_CYC cycles, then to TX_START.
  - TX_START: dat_oe=1 and clk_oe=0 in the same cycle; go to TX_BITS with bit index 0.
  - TX_BITS, per device clock fall:
    - falls 1–8 drive data bits 0–7, LSB first (dat_oe = ~bit)
    - fall 9 drives odd parity (dat_oe = ~(~^byte))
    - fall 10 releases data (stop bit); go to TX_ACK
  - TX_ACK, at fall 11: synchronized data 0 → WAIT_ACK; data 1 → retry.
  - WAIT_ACK, on rx_strobe:
    - 0xFA → next step
    - 0xFE → retry
    - any other byte → ignored
  - WAIT_BAT (after 0xFF is ACKed), on rx_strobe:
    - 0xAA → kbd_ok=1, IDLE
    - 0xFC → kbd_ok=0, err_cnt+1, IDLE
    - other bytes → ignored
- Retry rules:
  - Retry re-enters TX_INHIBIT with the same byte and increments the retry counter.
  - When the counter would exceed MAX_RETRY, the command is dropped: err_cnt+1, IDLE. A failed 0xFF also clears kbd_ok.
- Timeout: each of TX_BITS..TX_ACK together, WAIT_ACK and WAIT_BAT runs a cycle timer. On expiry, release both lines; WAIT_BAT expiry counts as failure, the others retry.
- LED sequence: byte 0xED → ACK → byte {5'b0, led_state} sampled at load time → ACK → IDLE.
- led_req arriving in any non-IDLE state sets a pending flag, which is serviced on the next IDLE cycle. Multiple requests collapse into one.
- rx_inhibit=1 from TX_INHIBIT through the TX_ACK decision; 0 elsewhere.
- busy=0 only in IDLE with nothing pending.

## Timing
- Reset values:
  - ps2_clk_oe=0, ps2_dat_oe=0, rx_inhibit=0
  - busy=1, kbd_ok=0, err_cnt=0
  - state POWERUP, retry count 0, pending 0
- Reset mid-frame releases both lines on the next CLOCK_50 edge.
- A device clock fall reaches the FSM 2 cycles after the pin transition; data is changed only in response to falls.
- Line drive change: same cycle as the state register update (registered outputs).
- rx_strobe coinciding with a timeout expiry: the byte wins.
- led_req coinciding with entry to IDLE: the LED sequence starts next cycle.

## Configuration
- PS2_HOST_LED_EN defined: LED sequence as above.
- PS2_HOST_LED_EN undefined: led_req and led_state are ignored, there is no pending flag, and only the power-up 0xFF sequence exists. busy falls after WAIT_BAT resolves.

## Test plan
- Power-up, BAT pass: after POWERUP_CYC, bench device clocks in 0xFF with parity 1 and ACKs at fall 11, then replies 0xFA, 0xAA → kbd_ok=1, busy=0, err_cnt=0.
- Resend: device replies 0xFE to the 0xFF frame once → second identical frame is sent, then FA/AA → kbd_ok=1, err_cnt=0.
- Silent device: no clocks after TX_START → MAX_RETRY+1 frames attempted, err_cnt=1, kbd_ok=0, both oe=0.
- LED update (macro on): led_state=3'b101, led_req pulse → frame 0xED, ACK FA, frame 0x05 with parity 1, ACK FA → busy=0.
- led_req pulsed twice during WAIT_BAT → exactly one ED/05 sequence follows.
- Reset asserted during TX_BITS fall 5 → next cycle ps2_clk_oe=0, ps2_dat_oe=0, rx_inhibit=0, busy=1, and POWERUP restarts.

Source files
------------

// File: rtl/ps2_host_sequencer.sv
// ps2_host_sequencer: PS/2 keyboard bring-up (0xFF/BAT) and LED command sequencer with retries and timeouts.
// Optional LED update path enabled by defining PS2_HOST_LED_EN.
module ps2_host_sequencer #(
  parameter int unsigned POWERUP_CYC      = 25000000,
  parameter int unsigned INHIBIT_CYC      = 5000,
  parameter int unsigned RESP_TIMEOUT_CYC = 1000000,
  parameter int unsigned BAT_TIMEOUT_CYC  = 50000000,
  parameter int unsigned MAX_RETRY        = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] rx_byte,
  input  logic       rx_strobe,
  output logic       rx_inhibit,
  input  logic [2:0] led_state,
  input  logic       led_req,
  output logic       busy,
  output logic       kbd_ok,
  output logic [7:0] err_cnt
);
  typedef enum logic [2:0] {POWERUP, IDLE, TX_INHIBIT, TX_START, TX_BITS, TX_ACK, WAIT_ACK, WAIT_BAT} state_t;
  state_t state, state_n;
  logic clk_s0, clk_s1, dat_s0, dat_s1, fall;
  logic [31:0] timer, timer_n, retry, retry_n;
  logic [3:0] bit_idx, bit_idx_n;
  logic [7:0] tx_byte, tx_byte_n, err_n;
  logic [1:0] step, step_n;
  logic pend, pend_n, kbd_ok_n, dat_bit, retry_req, fail;
  logic clk_oe_n, dat_oe_n, rx_inhibit_n, busy_n;
`ifndef PS2_HOST_LED_EN
  logic unused_led;
  assign unused_led = ^{led_req, led_state};
`endif
  assign fall = clk_s1 & ~clk_s0;
  always_comb begin
    state_n = state;
    timer_n = timer + 32'd1;
    bit_idx_n = bit_idx;
    tx_byte_n = tx_byte;
    step_n = step;
    retry_n = retry;
    pend_n = pend;
    kbd_ok_n = kbd_ok;
    err_n = err_cnt;
    dat_bit = ps2_dat_oe;
    retry_req = 1'b0;
    fail = 1'b0;
`ifdef PS2_HOST_LED_EN
    if (led_req && state != IDLE) pend_n = 1'b1;
`endif
    case (state)
      POWERUP: if (timer >= POWERUP_CYC - 1) begin
        tx_byte_n = 8'hFF;
        step_n = 2'd0;
        retry_n = 32'd0;
        timer_n = 32'd0;
        state_n = TX_INHIBIT;
      end
      IDLE: begin
        timer_n = 32'd0;
`ifdef PS2_HOST_LED_EN
        if (pend || led_req) begin
          pend_n = 1'b0;
          tx_byte_n = 8'hED;
          step_n = 2'd1;
          retry_n = 32'd0;
          state_n = TX_INHIBIT;
        end
`endif
      end
      TX_INHIBIT: if (timer >= INHIBIT_CYC - 1) state_n = TX_START;
      TX_START: begin
        bit_idx_n = 4'd0;
        timer_n = 32'd0;
        state_n = TX_BITS;
      end
      TX_BITS: if (fall) begin
        bit_idx_n = bit_idx + 4'd1;
        dat_bit = bit_idx < 4'd8 ? ~tx_byte[bit_idx[2:0]] : bit_idx == 4'd8 ? ^tx_byte : 1'b0;
        if (bit_idx == 4'd9) state_n = TX_ACK;
      end else if (timer >= RESP_TIMEOUT_CYC - 1) retry_req = 1'b1;
      TX_ACK: if (fall) begin
        retry_req = dat_s1;
        timer_n = 32'd0;
        state_n = dat_s1 ? state : WAIT_ACK;
      end else if (timer >= RESP_TIMEOUT_CYC - 1) retry_req = 1'b1;
      WAIT_ACK: if (rx_strobe) begin
        if (rx_byte == 8'hFA) begin
          timer_n = 32'd0;
          if (step == 2'd0) state_n = WAIT_BAT;
`ifdef PS2_HOST_LED_EN
          else if (step == 2'd1) begin
            tx_byte_n = {5'b0, led_state};
            step_n = 2'd2;
            retry_n = 32'd0;
            state_n = TX_INHIBIT;
          end
`endif
          else state_n = IDLE;
        end else if (rx_byte == 8'hFE) retry_req = 1'b1;
      end else if (timer >= RESP_TIMEOUT_CYC - 1) retry_req = 1'b1;
      WAIT_BAT: if (rx_strobe) begin
        if (rx_byte == 8'hAA) begin
          kbd_ok_n = 1'b1;
          state_n = IDLE;
        end else if (rx_byte == 8'hFC) fail = 1'b1;
      end else if (timer >= BAT_TIMEOUT_CYC - 1) fail = 1'b1;
    endcase
    // a retry past the budget turns into a dropped command
    if (retry_req) begin
      if (retry >= MAX_RETRY) fail = 1'b1;
      else begin
        retry_n = retry + 32'd1;
        timer_n = 32'd0;
        state_n = TX_INHIBIT;
      end
    end
    if (fail) begin
      err_n = err_cnt + {7'd0, err_cnt != 8'hFF};
      if (step == 2'd0) kbd_ok_n = 1'b0;
      state_n = IDLE;
    end
    clk_oe_n = state_n == TX_INHIBIT;
    dat_oe_n = state_n == TX_START || ((state_n == TX_BITS || state_n == TX_ACK) && dat_bit);
    rx_inhibit_n = state_n inside {TX_INHIBIT, TX_START, TX_BITS, TX_ACK};
    busy_n = !(state_n == IDLE && !pend_n);
  end
  always_ff @(posedge CLOCK_50) begin
    clk_s0 <= ps2_clk_in;
    clk_s1 <= clk_s0;
    dat_s0 <= ps2_dat_in;
    dat_s1 <= dat_s0;
    if (!reset_n) begin
      state <= POWERUP;
      timer <= 32'd0;
      bit_idx <= 4'd0;
      tx_byte <= 8'hFF;
      step <= 2'd0;
      retry <= 32'd0;
      pend <= 1'b0;
      kbd_ok <= 1'b0;
      err_cnt <= 8'd0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      rx_inhibit <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= state_n;
      timer <= timer_n;
      bit_idx <= bit_idx_n;
      tx_byte <= tx_byte_n;
      step <= step_n;
      retry <= retry_n;
      pend <= pend_n;
      kbd_ok <= kbd_ok_n;
      err_cnt <= err_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      rx_inhibit <= rx_inhibit_n;
      busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_ps2_host_sequencer.sv
// tb_ps2_host_sequencer: keyboard-side device model plus scoreboard of expected host frames.
module tb_ps2_host_sequencer;
  localparam int PU = 600, INH = 20, RT = 2000, BT = 3000, MR = 3;
  logic CLOCK_50 = 0, reset_n = 0;
  logic dev_clk_low = 0, dev_dat_low = 0;
  logic ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe, rx_inhibit, busy, kbd_ok;
  logic [7:0] rx_byte = 0, err_cnt;
  logic rx_strobe = 0, led_req = 0;
  logic [2:0] led_state = 0;
  int checks = 0, errors = 0, frames_seen = 0, fall_no = 0, starts = 0;
  int exp_err = 0;
  logic exp_kbd = 0, prev_clk_oe = 0;
  bit dev_silent = 0, drop_frame = 0;
  logic [7:0] exp_q[$];

  always #10 CLOCK_50 = ~CLOCK_50;
  assign ps2_clk_in = !(ps2_clk_oe || dev_clk_low);
  assign ps2_dat_in = !(ps2_dat_oe || dev_dat_low);

  ps2_host_sequencer #(.POWERUP_CYC(PU), .INHIBIT_CYC(INH), .RESP_TIMEOUT_CYC(RT),
    .BAT_TIMEOUT_CYC(BT), .MAX_RETRY(MR)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .rx_inhibit(rx_inhibit), .led_state(led_state), .led_req(led_req), .busy(busy),
    .kbd_ok(kbd_ok), .err_cnt(err_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // counts host frame starts: data pulled low in the cycle the clock inhibit ends
  always @(negedge CLOCK_50) begin
    if (ps2_dat_oe && !ps2_clk_oe && prev_clk_oe) starts++;
    prev_clk_oe = ps2_clk_oe;
  end

  // device side: clocks the host frame in, ACKs at fall 11, scores it against the queue
  task automatic device_frame;
    logic [9:0] bits;
    logic [7:0] e;
    repeat (10) @(negedge CLOCK_50);
    for (int k = 1; k <= 11; k++) begin
      fall_no = k;
      dev_clk_low = 1;
      repeat (20) @(negedge CLOCK_50);
      dev_clk_low = 0;
      if (k <= 10) bits[k-1] = ps2_dat_in;
      if (k == 10) begin
        repeat (5) @(negedge CLOCK_50);
        dev_dat_low = 1;
        repeat (15) @(negedge CLOCK_50);
      end else repeat (20) @(negedge CLOCK_50);
      if (k == 11) dev_dat_low = 0;
    end
    fall_no = 0;
    if (drop_frame) drop_frame = 0;
    else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got %0h expected none", bits[7:0]);
    end else begin
      e = exp_q.pop_front();
      check("frame_byte", {24'd0, bits[7:0]}, {24'd0, e});
      check("frame_parity", {31'd0, bits[8]}, ($countones(e) % 2 == 0) ? 1 : 0);
      check("frame_stop", {31'd0, bits[9]}, 1);
    end
    frames_seen++;
  endtask

  initial forever begin
    @(negedge CLOCK_50);
    if (!dev_silent && reset_n && ps2_dat_oe && !ps2_clk_oe) device_frame();
  end

  task automatic pulse_rx(input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_byte = b;
    rx_strobe = 1;
    @(negedge CLOCK_50);
    rx_strobe = 0;
  endtask

  task automatic pulse_led;
    @(negedge CLOCK_50);
    led_req = 1;
    @(negedge CLOCK_50);
    led_req = 0;
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames_seen < n && t < 20000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("frame_arrived", {31'd0, frames_seen >= n}, 1);
  endtask

  task automatic wait_idle;
    int t = 0;
    while (busy && t < 20000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("idle_reached", {31'd0, busy}, 0);
  endtask

  task automatic do_reset;
    @(negedge CLOCK_50);
    reset_n = 0;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1;
    exp_kbd = 0;
    exp_err = 0;
    exp_q.delete();
  endtask

  // model of one command: the same byte is resent after each 0xFE, dropped after MR resends
  task automatic send_cmd(input logic [7:0] b, input int nfe, output bit ok);
    ok = 0;
    for (int a = 0; a <= MR; a++) begin
      int target;
      target = frames_seen + 1;
      exp_q.push_back(b);
      wait_frames(target);
      if ($urandom_range(0, 1) == 1) pulse_rx(8'($urandom_range(0, 8'h9F)));
      if (a < nfe) pulse_rx(8'hFE);
      else begin
        pulse_rx(8'hFA);
        ok = 1;
        return;
      end
    end
  endtask

  task automatic finish_status;
    wait_idle();
    check("kbd_ok", {31'd0, kbd_ok}, {31'd0, exp_kbd});
    check("err_cnt", {24'd0, err_cnt}, exp_err);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic run_powerup(input int nfe, input bit pass);
    bit ok;
    send_cmd(8'hFF, nfe, ok);
    if (ok) begin
      if ($urandom_range(0, 1) == 1) pulse_rx(8'($urandom_range(0, 8'h9F)));
      pulse_rx(pass ? 8'hAA : 8'hFC);
      exp_kbd = pass;
      if (!pass) exp_err++;
    end else begin
      exp_kbd = 0;
      exp_err++;
    end
    finish_status();
  endtask

`ifdef PS2_HOST_LED_EN
  task automatic run_led(input logic [2:0] l, input int nfe0, input int nfe1);
    bit ok;
    led_state = l;
    pulse_led();
    send_cmd(8'hED, nfe0, ok);
    if (ok) send_cmd({5'b0, l}, nfe1, ok);
    if (!ok) exp_err++;
    finish_status();
  endtask
`endif

  initial begin
    int s0, f0, t;
    bit ok;
    repeat (2) @(negedge CLOCK_50);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("rst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("rst_rx_inhibit", {31'd0, rx_inhibit}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_kbd_ok", {31'd0, kbd_ok}, 0);
    check("rst_err_cnt", {24'd0, err_cnt}, 0);
    reset_n = 1;
    run_powerup(0, 1);
    do_reset();
    run_powerup(1, 1);
    for (int i = 0; i < 3; i++) begin
      do_reset();
      run_powerup($urandom_range(0, MR + 1), 1'($urandom_range(0, 1)));
    end
`ifdef PS2_HOST_LED_EN
    do_reset();
    run_powerup(0, 1);
    run_led(3'b101, 0, 0);
    for (int i = 0; i < 3; i++)
      run_led(3'($urandom), $urandom_range(0, 1), $urandom_range(0, MR + 1));
    do_reset();
    led_state = 3'b011;
    send_cmd(8'hFF, 0, ok);
    pulse_led();
    repeat (5) @(negedge CLOCK_50);
    pulse_led();
    pulse_rx(8'hAA);
    exp_kbd = 1;
    send_cmd(8'hED, 0, ok);
    send_cmd(8'h03, 0, ok);
    finish_status();
    f0 = frames_seen;
    repeat (1500) @(negedge CLOCK_50);
    check("single_led_seq", frames_seen, f0);
`endif
    do_reset();
    dev_silent = 1;
    s0 = starts;
    wait_idle();
    check("silent_attempts", starts - s0, MR + 1);
    check("silent_err_cnt", {24'd0, err_cnt}, 1);
    check("silent_kbd_ok", {31'd0, kbd_ok}, 0);
    check("silent_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("silent_dat_oe", {31'd0, ps2_dat_oe}, 0);
    dev_silent = 0;
    do_reset();
    t = 0;
    while (fall_no != 5 && t < 20000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("reached_fall5", fall_no, 5);
    repeat (4) @(negedge CLOCK_50);
    check("midframe_inhibit", {31'd0, rx_inhibit}, 1);
    drop_frame = 1;
    s0 = starts;
    reset_n = 0;
    @(negedge CLOCK_50);
    check("midrst_clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("midrst_dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("midrst_rx_inhibit", {31'd0, rx_inhibit}, 0);
    check("midrst_busy", {31'd0, busy}, 1);
    @(negedge CLOCK_50);
    reset_n = 1;
    exp_q.delete();
    exp_kbd = 0;
    exp_err = 0;
    t = 0;
    while (drop_frame && t < 20000) begin
      @(negedge CLOCK_50);
      t++;
    end
    check("dropped_frame_done", {31'd0, drop_frame}, 0);
    check("powerup_wait_restarted", starts - s0, 0);
    run_powerup(0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
